// File: rtl/issue_ibuffer.sv
// Per-warp decoded-instruction buffer: one small FIFO per warp, round-robin
// warp selection, and a registered valid/ready output toward dispatch.
module issue_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2,
  parameter int DATAW     = 128,
  localparam int NW_BITS  = $clog2(NUM_WARPS),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NW_BITS-1:0]   in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NW_BITS-1:0]   out_wid,
  output logic [DATAW-1:0]     out_data,
  output logic [NUM_WARPS-1:0] full,
  output logic [NUM_WARPS-1:0] empty
);

  logic [DATAW-1:0]   mem    [NUM_WARPS][DEPTH];
  logic [CNT_W-1:0]   count  [NUM_WARPS];
  logic [PTR_W-1:0]   rd_ptr [NUM_WARPS];
  logic [PTR_W-1:0]   wr_ptr [NUM_WARPS];
  logic [NW_BITS-1:0] rr_ptr;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic [NW_BITS-1:0]   grant;
  logic [NW_BITS-1:0]   idx;
  logic                 any_elig;
  logic                 load;
  logic                 push;
  logic                 pop;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = (count[w] != '0);
      full[w]     = (count[w] == CNT_W'(DEPTH));
      empty[w]    = (count[w] == '0) && !(out_valid && (out_wid == NW_BITS'(w)));
    end
  end

  // Full is checked without crediting a same-cycle pop of that warp.
  assign in_ready = !full[in_wid];
  assign push     = in_valid && in_ready;
  assign load     = !out_valid || out_ready;
  assign pop      = load && any_elig;

  // Scan from the farthest offset down so the nearest warp above rr_ptr wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any_elig = 1'b0;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      idx = rr_ptr + NW_BITS'(i);
      if (eligible[idx]) begin
        grant    = idx;
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (push) push_vec[in_wid] = 1'b1;
    if (pop)  pop_vec[grant]   = 1'b1;
  end

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[in_wid][wr_ptr[in_wid]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
        if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
        if (push_vec[w] && !pop_vec[w])      count[w] <= count[w] + CNT_W'(1);
        else if (!push_vec[w] && pop_vec[w]) count[w] <= count[w] - CNT_W'(1);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= NW_BITS'(NUM_WARPS - 1);
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= any_elig;
      if (any_elig) begin
        out_wid  <= grant;
        out_data <= mem[grant][rd_ptr[grant]];
        rr_ptr   <= grant;
      end
    end
  end

endmodule
